gpu_pixel_fifo: RTL and testbench
=================================

Name: gpu_pixel_fifo

Overview:
- Downstream of the GPU tile fetcher: accepts one fetched tile row per transfer (high and low bitplane bytes) and buffers it as eight 2-bit colour indices.
- Discards SCX fine-scroll pixels at line start, maps indices through the BGP palette, and streams one shade per clock to the LCD driver under a valid/ready handshake.
- Counts 160 visible pixels per scanline and flags end of line so the GPU mode controller can enter HORIZONTAL_BLANK.

Parameters:
- DEPTH, 16, pixel entries buffered (two tile rows); power of two, at least 8.
- LINE_PIXELS, 160, visible pixels emitted per scanline.

Ports:
- iClock  input  1  system clock, rising edge.
- iReset  input  1  asynchronous, active-low reset.
- iLineStart  input  1  one-cycle pulse: new scanline; flush buffer and load iScxFine.
- iScxFine  input  3  SCX[2:0]; pixels to discard at line start.
- iBgp  input  8  BGP palette register; shade for index n = iBgp[2n+1:2n].
- iTileValid  input  1  fetcher presents a tile row.
- iTileHigh  input  8  bitplane high byte (bh).
- iTileLow  input  8  bitplane low byte (bl).
- oTileReady  output  1  buffer accepts a tile row this cycle.
- oPixelValid  output  1  oPixel is valid.
- oPixel  output  2  palette-mapped shade.
- iPixelReady  input  1  LCD driver consumes the pixel.
- oPixelCount  output  8  pixels emitted on the current line, 0..160.
- oLineDone  output  1  one-cycle pulse after the 160th pixel transfer.

Behaviour:
- Reset (iReset=0, asynchronous): buffer empty, pointers 0, count 0, state IDLE, oPixelCount=0, oLineDone=0, oTileReady=0, oPixelValid=0, oPixel=0.
- Storage: DEPTH x 2-bit array, 4-bit read and write pointers that wrap modulo DEPTH, 5-bit count in the range 0..DEPTH.
- Push:
  - Accept when iTileValid && oTileReady.
  - Writes 8 entries at wr, wr+1, ..., wr+7 (wrapping), in order bit 7 first. Entry k = {iTileHigh[7-k], iTileLow[7-k]}.
  - oTileReady = (DEPTH - count >= 8) && !iLineStart && state != DONE. Uses count before any same-cycle pop.
- Pop: at most one entry per cycle. Push and pop in the same cycle are legal; count += 8 - 1.
- States:
  - IDLE: no output. On iLineStart: flush (pointers and count to 0), discard counter = iScxFine, oPixelCount=0, go to DISCARD.
  - DISCARD: while discard > 0 and count > 0, pop one entry per cycle without output and decrement discard. When discard == 0, go to RUN. If iScxFine=0, pass through DISCARD for one cycle.
  - RUN:
    - oPixelValid = (count > 0), combinational; oPixel = iBgp[2*head+1 : 2*head], combinational from the head entry and the current iBgp.
    - On valid && iPixelReady: pop and increment oPixelCount.
    - When the transfer that makes oPixelCount reach LINE_PIXELS completes, go to DONE.
  - DONE: oLineDone=1 for exactly one cycle, then go to IDLE. The residual buffer is kept until the next iLineStart flush.
- iLineStart in any state takes priority: flush and restart in DISCARD. A tile offered in the same cycle is not accepted (ready is low).
- oPixelValid stays high while iPixelReady is low; oPixel must remain stable unless iBgp changes (a BGP write mid-line takes effect immediately).
- Underflow (count 0 in RUN): oPixelValid=0; no pixel is lost or duplicated.
- No overflow is possible, because oTileReady guarantees 8 free entries.
- Latency: a tile accepted in cycle N with the buffer empty in RUN gives oPixelValid=1 in cycle N+1.

Decomposition:
- Shared package gpu_pkg: GPU state constants (HORIZONTAL_BLANK=0, VERTICAL_BLANK=1, SCANLINE_OAM_READ=2, SCANLINE_VRAM_READ=3, GPU_RESET=4), plus LINE_PIXELS and the FIFO state encodings IDLE, DISCARD, RUN, DONE.
- One sub-module, gpu_palette_map: combinational 2-bit index + 8-bit BGP to 2-bit shade, reused later for OBP0/OBP1 in sprite mixing.

Test Plan:
- Identity palette, no scroll: iBgp=0xE4, iScxFine=0, tile bh=0xF0 bl=0xCC, iPixelReady=1 -> oPixel sequence 3,3,2,2,1,1,0,0.
- Reversed palette: iBgp=0x1B, same tile -> 0,0,1,1,2,2,3,3.
- Fine scroll: iScxFine=5, tiles bh=0x00 bl=0xFF then bh=0xFF bl=0x00 -> first output pixels 1,1,1,2,...; exactly 5 pops with oPixelValid=0.
- Backpressure and full: feed tiles continuously with iPixelReady=0 -> exactly 2 tiles accepted, then oTileReady=0. Release ready -> 16 pixels out in order, none lost or duplicated.
- Full line: 20 tiles, random ready stalls, iScxFine=0 -> exactly 160 transfers, oPixelCount=160, oLineDone high for 1 cycle, oPixelValid=0 afterwards.
- Restart and reset: iLineStart at pixel 37 -> count flushed, oPixelCount=0, same-cycle tile rejected. iReset low mid-RUN -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: mode-controller states, line geometry and pixel FIFO states.
package gpu_pkg;

  typedef enum logic [2:0] {
    HORIZONTAL_BLANK   = 3'd0,
    VERTICAL_BLANK     = 3'd1,
    SCANLINE_OAM_READ  = 3'd2,
    SCANLINE_VRAM_READ = 3'd3,
    GPU_RESET          = 3'd4
  } gpu_state_e;

  localparam int unsigned LINE_PIXELS = 160;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } fifo_state_e;

endpackage

// File: rtl/gpu_pixel_fifo_if.sv
// Fetcher-side tile transfer, LCD-side pixel stream and line control of the pixel FIFO.
interface gpu_pixel_fifo_if;
  logic       iLineStart;
  logic [2:0] iScxFine;
  logic [7:0] iBgp;
  logic       iTileValid;
  logic [7:0] iTileHigh;
  logic [7:0] iTileLow;
  logic       oTileReady;
  logic       oPixelValid;
  logic [1:0] oPixel;
  logic       iPixelReady;
  logic [7:0] oPixelCount;
  logic       oLineDone;

  modport slave (
    input  iLineStart, iScxFine, iBgp, iTileValid, iTileHigh, iTileLow, iPixelReady,
    output oTileReady, oPixelValid, oPixel, oPixelCount, oLineDone
  );

  modport master (
    output iLineStart, iScxFine, iBgp, iTileValid, iTileHigh, iTileLow, iPixelReady,
    input  oTileReady, oPixelValid, oPixel, oPixelCount, oLineDone
  );
endinterface

// File: rtl/gpu_palette_map.sv
// Maps a 2-bit colour index through an 8-bit DMG palette register to a 2-bit shade.
module gpu_palette_map (
  input  logic [1:0] idx_i,
  input  logic [7:0] palette_i,
  output logic [1:0] shade_o
);
  always_comb begin
    unique case (idx_i)
      2'd0: shade_o = palette_i[1:0];
      2'd1: shade_o = palette_i[3:2];
      2'd2: shade_o = palette_i[5:4];
      2'd3: shade_o = palette_i[7:6];
    endcase
  end
endmodule

// File: rtl/gpu_pixel_fifo.sv
// Background pixel FIFO: buffers tile rows as 2-bit indices, drops SCX fine-scroll pixels,
// and streams BGP-mapped shades to the LCD, flagging the end of each 160-pixel line.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LINE_PIXELS = gpu_pkg::LINE_PIXELS
) (
  input logic             iClock,
  input logic             iReset,
  gpu_pixel_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fifo_state_e     state_q, state_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      discard_q, discard_d;
  logic [7:0]      pix_cnt_q, pix_cnt_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];

  logic       tile_ready, push, pop, pixel_valid;
  logic [1:0] head_idx, shade;

  assign head_idx = mem_q[rd_q];

  gpu_palette_map u_bgp_map (
    .idx_i     (head_idx),
    .palette_i (bus.iBgp),
    .shade_o   (shade)
  );

  always_comb begin
    // Ready is forced low while reset is held so every output reads zero.
    tile_ready  = iReset && !bus.iLineStart && (state_q != DONE) &&
                  (count_q <= CntW'(DEPTH - 8));
    push        = bus.iTileValid && tile_ready;
    pixel_valid = (state_q == RUN) && (count_q != '0);
    pop         = 1'b0;
    state_d     = state_q;
    discard_d   = discard_q;
    pix_cnt_d   = pix_cnt_q;

    case (state_q)
      IDLE: ;
      DISCARD: begin
        if (discard_q == 3'd0) begin
          state_d = RUN;
        end else if (count_q != '0) begin
          pop       = 1'b1;
          discard_d = discard_q - 3'd1;
        end
      end
      RUN: begin
        if (pixel_valid && bus.iPixelReady) begin
          pop       = 1'b1;
          pix_cnt_d = pix_cnt_q + 8'd1;
          if (pix_cnt_q == 8'(LINE_PIXELS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_d    = push ? wr_q + PtrW'(8) : wr_q;
    rd_d    = pop ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q + (push ? CntW'(8) : CntW'(0)) - (pop ? CntW'(1) : CntW'(0));

    mem_d = mem_q;
    if (push) begin
      for (int k = 0; k < 8; k++) begin
        mem_d[wr_q + PtrW'(k)] = {bus.iTileHigh[7-k], bus.iTileLow[7-k]};
      end
    end

    // A new line overrides everything, including a pop or push decided above.
    if (bus.iLineStart) begin
      state_d   = DISCARD;
      discard_d = bus.iScxFine;
      pix_cnt_d = '0;
      wr_d      = '0;
      rd_d      = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      discard_q <= '0;
      pix_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      pix_cnt_q <= pix_cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.oTileReady  = tile_ready;
  assign bus.oPixelValid = pixel_valid;
  assign bus.oPixel      = pixel_valid ? shade : 2'b00;
  assign bus.oPixelCount = pix_cnt_q;
  assign bus.oLineDone   = (state_q == DONE);
endmodule

// File: tb/tb_gpu_pixel_fifo.sv
// Directed bench for gpu_pixel_fifo: palette/scroll vector table plus backpressure,
// full-line, restart and reset sequences.
module tb_gpu_pixel_fifo;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_pixel_fifo_if bus ();

  gpu_pixel_fifo #(
    .DEPTH       (16),
    .LINE_PIXELS (160)
  ) dut (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  bgp;
    logic [2:0]  scx;
    logic [7:0]  h0, l0, h1, l1;
    logic [15:0] exp;  // pixel i at [2*i+1:2*i]
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int p0, p1, p2, p3, p4, p5, p6, p7);
    logic [15:0] r;
    r = {2'(p7), 2'(p6), 2'(p5), 2'(p4), 2'(p3), 2'(p2), 2'(p1), 2'(p0)};
    return r;
  endfunction

  function automatic int ref_shade(input logic [7:0] pal, input logic [7:0] h,
                                   input logic [7:0] l, input int k);
    logic [1:0] idx;
    idx = {h[7-k], l[7-k]};
    return int'(pal[2*idx +: 2]);
  endfunction

  task automatic line_start(input logic [7:0] bgp, input logic [2:0] scx);
    @(negedge clk);
    bus.iBgp       = bgp;
    bus.iScxFine   = scx;
    bus.iLineStart = 1'b1;
    bus.iTileValid = 1'b0;
    @(negedge clk);
    bus.iLineStart = 1'b0;
  endtask

  initial begin
    int sent, got, acc, xfers, post, done_cycles, e;
    logic [15:0] px;
    logic [31:0] bp_exp;
    int exp_q[$];
    vec_t v;

    vecs[0] = '{8'hE4, 3'd0, 8'hF0, 8'hCC, 8'hF0, 8'hCC, pk(3, 3, 2, 2, 1, 1, 0, 0)};
    vecs[1] = '{8'h1B, 3'd0, 8'hF0, 8'hCC, 8'hF0, 8'hCC, pk(0, 0, 1, 1, 2, 2, 3, 3)};
    vecs[2] = '{8'hE4, 3'd5, 8'h00, 8'hFF, 8'hFF, 8'h00, pk(1, 1, 1, 2, 2, 2, 2, 2)};
    vecs[3] = '{8'h9C, 3'd7, 8'h5A, 8'h3C, 8'h5A, 8'h3C, pk(0, 0, 1, 3, 2, 2, 3, 1)};

    bus.iLineStart  = 1'b0;
    bus.iScxFine    = 3'd0;
    bus.iBgp        = 8'hE4;
    bus.iTileValid  = 1'b0;
    bus.iTileHigh   = 8'h00;
    bus.iTileLow    = 8'h00;
    bus.iPixelReady = 1'b0;

    // Reset values while reset is held
    #1;
    check("rst_tile_ready", bus.oTileReady, 0);
    check("rst_pixel_valid", bus.oPixelValid, 0);
    check("rst_pixel", bus.oPixel, 0);
    check("rst_pixel_count", bus.oPixelCount, 0);
    check("rst_line_done", bus.oLineDone, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: palette and fine-scroll combinations
    for (int r = 0; r < 4; r++) begin
      v = vecs[r];
      bus.iPixelReady = 1'b1;
      line_start(v.bgp, v.scx);
      sent = 0;
      got  = 0;
      px   = '0;
      for (int c = 0; c < 60 && got < 8; c++) begin
        bus.iTileValid = (sent < 2);
        bus.iTileHigh  = (sent == 0) ? v.h0 : v.h1;
        bus.iTileLow   = (sent == 0) ? v.l0 : v.l1;
        #1;
        if (bus.iTileValid && bus.oTileReady) sent++;
        if (bus.oPixelValid) begin
          px[2*got +: 2] = bus.oPixel;
          got++;
        end
        @(negedge clk);
      end
      bus.iPixelReady = 1'b0;
      bus.iTileValid  = 1'b0;
      #1;
      check($sformatf("vec%0d_got", r), got, 8);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("vec%0d_px%0d", r, i), int'(px[2*i +: 2]), int'(v.exp[2*i +: 2]));
      end
      check($sformatf("vec%0d_count", r), bus.oPixelCount, 8);
    end

    // Backpressure: only two tiles fit, output holds steady, BGP write is immediate
    bus.iPixelReady = 1'b0;
    line_start(8'hE4, 3'd0);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      bus.iTileValid = 1'b1;
      bus.iTileHigh  = (acc == 0) ? 8'hF0 : 8'h0F;
      bus.iTileLow   = (acc == 0) ? 8'hCC : 8'h55;
      #1;
      if (bus.oTileReady) acc++;
      @(negedge clk);
    end
    bus.iTileValid = 1'b0;
    #1;
    check("bp_tiles_accepted", acc, 2);
    check("bp_ready_low", bus.oTileReady, 0);
    check("bp_valid_held", bus.oPixelValid, 1);
    check("bp_pixel_held", bus.oPixel, 3);
    bus.iBgp = 8'h1B;
    #1;
    check("bp_bgp_live", bus.oPixel, 0);
    bus.iBgp = 8'hE4;
    #1;
    bp_exp = {pk(0, 1, 0, 1, 2, 3, 2, 3), pk(3, 3, 2, 2, 1, 1, 0, 0)};
    bus.iPixelReady = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (bus.oPixelValid) begin
        check($sformatf("bp_px%0d", got), bus.oPixel, int'(bp_exp[2*got +: 2]));
        got++;
      end
      @(negedge clk);
      #1;
    end
    check("bp_got", got, 16);
    check("bp_underflow_valid", bus.oPixelValid, 0);
    check("bp_count", bus.oPixelCount, 16);

    // Full line with random stalls against a scoreboard
    line_start(8'hD2, 3'd0);
    sent = 0;
    xfers = 0;
    post = 0;
    done_cycles = 0;
    for (int c = 0; c < 3000 && post < 6; c++) begin
      bus.iTileValid  = (sent < 20);
      bus.iTileHigh   = 8'(sent * 37 + 5);
      bus.iTileLow    = 8'(sent * 91 + 3);
      bus.iPixelReady = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.iTileValid && bus.oTileReady) begin
        for (int k = 0; k < 8; k++) exp_q.push_back(ref_shade(8'hD2, bus.iTileHigh,
                                                              bus.iTileLow, k));
        sent++;
      end
      if (bus.oLineDone) begin
        done_cycles++;
        check("line_count_at_done", bus.oPixelCount, 160);
      end
      if (bus.oPixelValid && bus.iPixelReady) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check($sformatf("line_px%0d", xfers), bus.oPixel, e);
        xfers++;
      end
      if (xfers >= 160) post++;
      @(negedge clk);
    end
    bus.iTileValid  = 1'b0;
    bus.iPixelReady = 1'b1;
    #1;
    check("line_xfers", xfers, 160);
    check("line_tiles", sent, 20);
    check("line_done_cycles", done_cycles, 1);
    check("line_valid_after", bus.oPixelValid, 0);
    check("line_count_after", bus.oPixelCount, 160);

    // Restart at pixel 37: flush, reject same-cycle tile, fresh data next
    line_start(8'hE4, 3'd0);
    got = 0;
    for (int c = 0; c < 200 && got < 37; c++) begin
      bus.iTileValid = 1'b1;
      bus.iTileHigh  = 8'h0F;
      bus.iTileLow   = 8'h55;
      #1;
      if (bus.oPixelValid) got++;
      @(negedge clk);
    end
    #1;
    check("rs_count_37", bus.oPixelCount, 37);
    bus.iLineStart = 1'b1;
    bus.iTileHigh  = 8'hF0;
    bus.iTileLow   = 8'hCC;
    #1;
    check("rs_tile_rejected", bus.oTileReady, 0);
    @(negedge clk);
    bus.iLineStart = 1'b0;
    bus.iTileValid = 1'b0;
    #1;
    check("rs_count_flushed", bus.oPixelCount, 0);
    check("rs_valid_flushed", bus.oPixelValid, 0);
    @(negedge clk);
    bus.iTileValid = 1'b1;
    #1;
    check("rs_ready_empty", bus.oTileReady, 1);
    @(negedge clk);
    bus.iTileValid = 1'b0;
    #1;
    check("rs_latency_valid", bus.oPixelValid, 1);
    check("rs_fresh_pixel", bus.oPixel, 3);
    @(negedge clk);
    #1;
    check("rs_count_1", bus.oPixelCount, 1);

    // Asynchronous reset mid-RUN, then IDLE produces no output
    bus.iPixelReady = 1'b0;
    line_start(8'hE4, 3'd0);
    @(negedge clk);
    bus.iTileValid = 1'b1;
    @(negedge clk);
    bus.iTileValid = 1'b0;
    #1;
    check("ar_pre_valid", bus.oPixelValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tile_ready", bus.oTileReady, 0);
    check("ar_pixel_valid", bus.oPixelValid, 0);
    check("ar_pixel", bus.oPixel, 0);
    check("ar_pixel_count", bus.oPixelCount, 0);
    check("ar_line_done", bus.oLineDone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.iTileValid = 1'b1;
    #1;
    check("ar_idle_ready", bus.oTileReady, 1);
    @(negedge clk);
    bus.iTileValid = 1'b0;
    bus.iPixelReady = 1'b1;
    #1;
    check("ar_idle_no_output", bus.oPixelValid, 0);
    @(negedge clk);
    #1;
    check("ar_idle_count", bus.oPixelCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
